vx_ipdom_ctrl: RTL and testbench
================================

// Module: VX_ipdom_ctrl
// PURPOSE
//  Split/join controller for the per-warp IPDOM divergence stacks. Accepts split and join requests
//  from the branch unit, keeps NUM_WARPS internal VX_ipdom_stack instances (one per warp), and
//  returns the new thread mask and PC for each warp. It sequences every push and pop, detects
//  uniform branches, and flags overflow and underflow.
// PARAMETERS
//  NUM_WARPS    4   warps; one stack per warp
//  NUM_THREADS  4   threads per warp (thread-mask width)
//  PC_BITS      32  PC width
//  DEPTH        4   entries per warp stack
//  NW_BITS      `LOG2UP(NUM_WARPS)   derived, warp-id width
//  SP_BITS      `LOG2UP(DEPTH)       derived, stack-pointer width
// PORTS
//  clk            in   1            clock
//  reset          in   1            synchronous active-high reset
//  req_valid      in   1            request valid
//  req_ready      out  1            request accepted when req_valid & req_ready
//  req_is_join    in   1            1 = join, 0 = split
//  req_wid        in   NW_BITS      warp id
//  req_tmask      in   NUM_THREADS  current warp thread mask
//  req_then_tmask in   NUM_THREADS  split only: threads taking the branch (already ANDed with tmask)
//  req_else_pc    in   PC_BITS      split only: PC of the else path
//  rsp_valid      out  1            response valid
//  rsp_ready      in   1            response consumed
//  rsp_wid        out  NW_BITS      warp id of the response
//  rsp_tmask      out  NUM_THREADS  thread mask the warp uses from now on
//  rsp_pc         out  PC_BITS      redirect PC; meaningful only when rsp_redirect=1
//  rsp_redirect   out  1            warp must jump to rsp_pc
//  rsp_divergent  out  1            split pushed an entry
//  rsp_err        out  1            overflow (split on a full stack) or underflow (join on an empty stack)
//  rsp_sp         out  SP_BITS      stack pointer of the warp after the operation
//  warp_empty     out  NUM_WARPS    per-warp stack-empty flags
// BEHAVIOUR
//  Reset: rsp_valid=0; all other rsp_* outputs = 0; warp_empty = all ones; every stack is empty.
//  Handshake: req_ready = ~rsp_valid | rsp_ready.
//   - A request accepted at cycle N produces rsp_valid at N+1.
//   - rsp_* holds stable while rsp_valid & ~rsp_ready.
//   - Throughput is 1 request per cycle. The block never pushes and pops the same stack in one cycle.
//  Stack entry = {tmask, pc}. Push writes q0 = {req_tmask, 0} and q1 = {req_tmask & ~req_then_tmask, req_else_pc}.
//  Split:
//   - then = req_then_tmask, else = req_tmask & ~then.
//   - Uniform case (then==0 or else==0): no push. rsp_tmask = req_tmask, rsp_divergent=0, rsp_redirect=0.
//   - Divergent case, stack not full: push. rsp_tmask = then, rsp_divergent=1, rsp_redirect=0.
//   - Divergent case, stack full: no push. rsp_err=1, rsp_tmask = req_tmask.
//  Join (stack read is combinational, the pop is committed at acceptance):
//   - Top entry unset (first join): pop returns the else half. rsp_tmask = else mask, rsp_pc = else pc,
//     rsp_redirect=1. The entry is marked set and the pointer does not move.
//   - Top entry set (second join): pop returns the saved tmask. rsp_redirect=0. The pointer decrements.
//   - Stack empty: no pop. rsp_err=1, rsp_tmask = req_tmask, rsp_redirect=0.
//  rsp_sp = the warp stack's q_ptr after the update. warp_empty[w] updates the cycle after the push or pop.
//  Back-to-back requests to the same warp see the state updated by the previous accepted request;
//  there is no bypass hazard because the update commits at acceptance.
//  Reset mid-operation: any pending response is dropped and all stacks clear.
// TESTING
//  1 Reset -> warp_empty=4'b1111, rsp_valid=0, req_ready=1.
//  2 Split w0 tmask=1111 then=1111 -> rsp_tmask=1111, divergent=0, no push, warp_empty[0]=1.
//  3 Split w1 tmask=1111 then=0011 else_pc=0x100 -> rsp_tmask=0011, divergent=1.
//    Join -> rsp_tmask=1100, pc=0x100, redirect=1.
//    Join -> rsp_tmask=1111, redirect=0, warp_empty[1]=1.
//  4 Four nested divergent splits on w2 (DEPTH=4), then a fifth -> rsp_err=1 and the fifth is not pushed.
//    Eight joins unwind in LIFO order.
//  5 Join on empty w3 -> rsp_err=1, rsp_tmask=req_tmask, stack unchanged.
//  6 Hold rsp_ready=0 for 3 cycles with req_valid=1 -> rsp_* stable, req_ready=0, no stack change.
//    Interleave w0/w1 splits back-to-back -> independent stacks.

Source files
------------

// File: rtl/vx_ipdom_ctrl.sv
// rtl/vx_ipdom_ctrl.sv - per-warp IPDOM split/join controller with divergence stacks
//
// vx_ipdom_stack: one warp's divergence stack.
//   clk, reset          clock, synchronous active-high reset
//   push                write {push_tmask0, push_tmask1, push_pc1} and advance count
//   pop                 first pop of an entry marks it set; second pop removes it
//   top_*               combinational view of the top entry
//   count, empty, full  occupancy
//
// vx_ipdom_ctrl: split/join sequencer over NUM_WARPS stacks.
//   req_*   request channel (valid/ready), split when req_is_join=0
//   rsp_*   registered response channel (valid/ready)
//   warp_empty  per-warp stack-empty flags

module vx_ipdom_stack #(
  parameter int NUM_THREADS = 4,
  parameter int PC_BITS     = 32,
  parameter int DEPTH       = 4,
  parameter int SP_BITS     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [NUM_THREADS-1:0] push_tmask0,
  input  logic [NUM_THREADS-1:0] push_tmask1,
  input  logic [PC_BITS-1:0]     push_pc1,
  input  logic                   pop,
  output logic [NUM_THREADS-1:0] top_tmask0,
  output logic [NUM_THREADS-1:0] top_tmask1,
  output logic [PC_BITS-1:0]     top_pc1,
  output logic                   top_set,
  output logic [SP_BITS:0]       count,
  output logic                   empty,
  output logic                   full
);
  logic [NUM_THREADS-1:0] mem_tmask0 [DEPTH];
  logic [NUM_THREADS-1:0] mem_tmask1 [DEPTH];
  logic [PC_BITS-1:0]     mem_pc1    [DEPTH];
  logic [DEPTH-1:0]       set_q;
  logic [SP_BITS-1:0]     wr_idx;
  logic [SP_BITS-1:0]     top_idx;

  assign wr_idx  = count[SP_BITS-1:0];
  assign top_idx = SP_BITS'(count - 1'b1);
  assign empty   = (count == '0);
  assign full    = (count == (SP_BITS+1)'(DEPTH));

  assign top_tmask0 = mem_tmask0[top_idx];
  assign top_tmask1 = mem_tmask1[top_idx];
  assign top_pc1    = mem_pc1[top_idx];
  assign top_set    = set_q[top_idx];

  // Entry payload needs no reset: it is only read while count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_tmask0[wr_idx] <= push_tmask0;
      mem_tmask1[wr_idx] <= push_tmask1;
      mem_pc1[wr_idx]    <= push_pc1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      set_q <= '0;
    end else if (push) begin
      set_q[wr_idx] <= 1'b0;
      count         <= count + 1'b1;
    end else if (pop) begin
      if (!set_q[top_idx]) begin
        set_q[top_idx] <= 1'b1;
      end else begin
        count <= count - 1'b1;
      end
    end
  end
endmodule

module vx_ipdom_ctrl #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_BITS     = 32,
  parameter int DEPTH       = 4,
  parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int SP_BITS     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_is_join,
  input  logic [NW_BITS-1:0]     req_wid,
  input  logic [NUM_THREADS-1:0] req_tmask,
  input  logic [NUM_THREADS-1:0] req_then_tmask,
  input  logic [PC_BITS-1:0]     req_else_pc,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [NW_BITS-1:0]     rsp_wid,
  output logic [NUM_THREADS-1:0] rsp_tmask,
  output logic [PC_BITS-1:0]     rsp_pc,
  output logic                   rsp_redirect,
  output logic                   rsp_divergent,
  output logic                   rsp_err,
  output logic [SP_BITS-1:0]     rsp_sp,
  output logic [NUM_WARPS-1:0]   warp_empty
);
  logic                   req_fire;
  logic [NUM_THREADS-1:0] else_tmask;
  logic                   uniform;

  logic [NUM_THREADS-1:0] top_tmask0 [NUM_WARPS];
  logic [NUM_THREADS-1:0] top_tmask1 [NUM_WARPS];
  logic [PC_BITS-1:0]     top_pc1    [NUM_WARPS];
  logic [NUM_WARPS-1:0]   top_set;
  logic [SP_BITS:0]       cnt        [NUM_WARPS];
  logic [NUM_WARPS-1:0]   full;

  logic [NUM_THREADS-1:0] nxt_tmask;
  logic [PC_BITS-1:0]     nxt_pc;
  logic                   nxt_redirect;
  logic                   nxt_divergent;
  logic                   nxt_err;
  logic [SP_BITS:0]       nxt_cnt;

  assign req_ready  = ~rsp_valid | rsp_ready;
  assign req_fire   = req_valid & req_ready;
  assign else_tmask = req_tmask & ~req_then_tmask;
  assign uniform    = (req_then_tmask == '0) || (else_tmask == '0);

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic sel;
    assign sel = (req_wid == NW_BITS'(w));

    // State commits at acceptance so a back-to-back request sees it next cycle.
    vx_ipdom_stack #(
      .NUM_THREADS (NUM_THREADS),
      .PC_BITS     (PC_BITS),
      .DEPTH       (DEPTH),
      .SP_BITS     (SP_BITS)
    ) u_stack (
      .clk         (clk),
      .reset       (reset),
      .push        (req_fire & ~req_is_join & sel & ~uniform & ~full[w]),
      .push_tmask0 (req_tmask),
      .push_tmask1 (else_tmask),
      .push_pc1    (req_else_pc),
      .pop         (req_fire & req_is_join & sel & ~warp_empty[w]),
      .top_tmask0  (top_tmask0[w]),
      .top_tmask1  (top_tmask1[w]),
      .top_pc1     (top_pc1[w]),
      .top_set     (top_set[w]),
      .count       (cnt[w]),
      .empty       (warp_empty[w]),
      .full        (full[w])
    );
  end

  always_comb begin
    nxt_tmask     = req_tmask;
    nxt_pc        = '0;
    nxt_redirect  = 1'b0;
    nxt_divergent = 1'b0;
    nxt_err       = 1'b0;
    nxt_cnt       = cnt[req_wid];
    if (req_is_join) begin
      if (warp_empty[req_wid]) begin
        nxt_err = 1'b1;
      end else if (!top_set[req_wid]) begin
        // First join of a divergent region: run the else half, pointer stays.
        nxt_tmask    = top_tmask1[req_wid];
        nxt_pc       = top_pc1[req_wid];
        nxt_redirect = 1'b1;
      end else begin
        nxt_tmask = top_tmask0[req_wid];
        nxt_cnt   = cnt[req_wid] - 1'b1;
      end
    end else if (!uniform) begin
      if (full[req_wid]) begin
        nxt_err = 1'b1;
      end else begin
        nxt_tmask     = req_then_tmask;
        nxt_divergent = 1'b1;
        nxt_cnt       = cnt[req_wid] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid     <= 1'b0;
      rsp_wid       <= '0;
      rsp_tmask     <= '0;
      rsp_pc        <= '0;
      rsp_redirect  <= 1'b0;
      rsp_divergent <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_sp        <= '0;
    end else if (req_fire) begin
      rsp_valid     <= 1'b1;
      rsp_wid       <= req_wid;
      rsp_tmask     <= nxt_tmask;
      rsp_pc        <= nxt_pc;
      rsp_redirect  <= nxt_redirect;
      rsp_divergent <= nxt_divergent;
      rsp_err       <= nxt_err;
      // Pointer wraps to 0 when the stack holds DEPTH entries.
      rsp_sp        <= nxt_cnt[SP_BITS-1:0];
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vx_ipdom_ctrl.sv
// tb/tb_vx_ipdom_ctrl.sv - directed self-checking bench for vx_ipdom_ctrl

module tb_vx_ipdom_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_join;
  logic [1:0]  req_wid;
  logic [3:0]  req_tmask;
  logic [3:0]  req_then_tmask;
  logic [31:0] req_else_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_wid;
  logic [3:0]  rsp_tmask;
  logic [31:0] rsp_pc;
  logic        rsp_redirect;
  logic        rsp_divergent;
  logic        rsp_err;
  logic [1:0]  rsp_sp;
  logic [3:0]  warp_empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_ipdom_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_join    (req_is_join),
    .req_wid        (req_wid),
    .req_tmask      (req_tmask),
    .req_then_tmask (req_then_tmask),
    .req_else_pc    (req_else_pc),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_wid        (rsp_wid),
    .rsp_tmask      (rsp_tmask),
    .rsp_pc         (rsp_pc),
    .rsp_redirect   (rsp_redirect),
    .rsp_divergent  (rsp_divergent),
    .rsp_err        (rsp_err),
    .rsp_sp         (rsp_sp),
    .warp_empty     (warp_empty)
  );

  // Packed snapshot: {valid, wid, tmask, pc, redirect, divergent, err, sp}
  function automatic logic [43:0] rsp_vec();
    return {rsp_valid, rsp_wid, rsp_tmask, rsp_pc, rsp_redirect, rsp_divergent, rsp_err, rsp_sp};
  endfunction

  // Drive one request for one cycle; returns at #1 after the accepting edge.
  task automatic issue(input logic j, input logic [1:0] w, input logic [3:0] tm,
                       input logic [3:0] th, input logic [31:0] pc);
    req_is_join = j; req_wid = w; req_tmask = tm; req_then_tmask = th; req_else_pc = pc;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_is_join = 1'b0; req_wid = '0; req_tmask = '0; req_then_tmask = '0; req_else_pc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (warp_empty !== 4'b1111) begin errors++; $display("FAIL reset_empty got %b exp 1111", warp_empty); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++;
    if (rsp_vec() !== 44'h0) begin errors++; $display("FAIL reset_rsp got %h exp 0", rsp_vec()); end
  endtask

  task automatic test_uniform();
    issue(1'b0, 2'd0, 4'b1111, 4'b1111, 32'h80);
    checks++;
    if (rsp_vec() !== {1'b1, 2'd0, 4'b1111, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL uniform_split got %h", rsp_vec());
    end
    checks++;
    if (warp_empty !== 4'b1111) begin errors++; $display("FAIL uniform_empty got %b exp 1111", warp_empty); end
  endtask

  task automatic test_split_join();
    issue(1'b0, 2'd1, 4'b1111, 4'b0011, 32'h100);
    checks++;
    if (rsp_vec() !== {1'b1, 2'd1, 4'b0011, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1}) begin
      errors++; $display("FAIL sj_split got %h", rsp_vec());
    end
    checks++;
    if (warp_empty !== 4'b1101) begin errors++; $display("FAIL sj_empty_after_push got %b exp 1101", warp_empty); end
    issue(1'b1, 2'd1, 4'b0011, 4'b0000, 32'h0);
    checks++;
    if (rsp_vec() !== {1'b1, 2'd1, 4'b1100, 32'h100, 1'b1, 1'b0, 1'b0, 2'd1}) begin
      errors++; $display("FAIL sj_join1 got %h", rsp_vec());
    end
    issue(1'b1, 2'd1, 4'b1100, 4'b0000, 32'h0);
    checks++;
    if (rsp_vec() !== {1'b1, 2'd1, 4'b1111, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL sj_join2 got %h", rsp_vec());
    end
    checks++;
    if (warp_empty !== 4'b1111) begin errors++; $display("FAIL sj_empty_after_pop got %b exp 1111", warp_empty); end
  endtask

  task automatic test_overflow_lifo();
    logic [3:0]  tm [4] = '{4'b1111, 4'b1111, 4'b1111, 4'b0111};
    logic [3:0]  th [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b0001};
    logic [31:0] pc [4] = '{32'h200, 32'h210, 32'h220, 32'h230};
    logic [1:0]  sp;
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, 2'd2, tm[k], th[k], pc[k]);
      sp = 2'(k + 1);
      checks++;
      if (rsp_vec() !== {1'b1, 2'd2, th[k], 32'h0, 1'b0, 1'b1, 1'b0, sp}) begin
        errors++; $display("FAIL nest_split%0d got %h", k, rsp_vec());
      end
    end
    issue(1'b0, 2'd2, 4'b1111, 4'b0101, 32'h2f0);
    checks++;
    if (rsp_vec() !== {1'b1, 2'd2, 4'b1111, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
      errors++; $display("FAIL overflow got %h", rsp_vec());
    end
    for (int k = 3; k >= 0; k--) begin
      issue(1'b1, 2'd2, th[k], 4'b0000, 32'h0);
      sp = 2'(k + 1);
      checks++;
      if (rsp_vec() !== {1'b1, 2'd2, tm[k] & ~th[k], pc[k], 1'b1, 1'b0, 1'b0, sp}) begin
        errors++; $display("FAIL unwind_first%0d got %h", k, rsp_vec());
      end
      issue(1'b1, 2'd2, tm[k] & ~th[k], 4'b0000, 32'h0);
      sp = 2'(k);
      checks++;
      if (rsp_vec() !== {1'b1, 2'd2, tm[k], 32'h0, 1'b0, 1'b0, 1'b0, sp}) begin
        errors++; $display("FAIL unwind_second%0d got %h", k, rsp_vec());
      end
    end
    checks++;
    if (warp_empty !== 4'b1111) begin errors++; $display("FAIL unwind_empty got %b exp 1111", warp_empty); end
  endtask

  task automatic test_underflow();
    issue(1'b1, 2'd3, 4'b1010, 4'b0000, 32'h0);
    checks++;
    if (rsp_vec() !== {1'b1, 2'd3, 4'b1010, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
      errors++; $display("FAIL underflow got %h", rsp_vec());
    end
    checks++;
    if (warp_empty !== 4'b1111) begin errors++; $display("FAIL underflow_empty got %b exp 1111", warp_empty); end
  endtask

  task automatic test_back_to_back();
    logic [43:0] held;
    @(posedge clk); #1;  // drain the previous response
    rsp_ready = 1'b0;
    issue(1'b0, 2'd0, 4'b1111, 4'b1001, 32'h300);
    held = {1'b1, 2'd0, 4'b1001, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1};
    checks++;
    if (rsp_vec() !== held) begin errors++; $display("FAIL stall_first got %h exp %h", rsp_vec(), held); end
    req_is_join = 1'b1; req_wid = 2'd0; req_tmask = 4'b1001; req_then_tmask = '0; req_else_pc = '0;
    req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d got %b exp 0", c, req_ready); end
      @(posedge clk); #1;
      checks++;
      if (rsp_vec() !== held) begin errors++; $display("FAIL stall_hold%0d got %h exp %h", c, rsp_vec(), held); end
      checks++;
      if (warp_empty !== 4'b1110) begin errors++; $display("FAIL stall_empty%0d got %b exp 1110", c, warp_empty); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (rsp_vec() !== {1'b1, 2'd0, 4'b0110, 32'h300, 1'b1, 1'b0, 1'b0, 2'd1}) begin
      errors++; $display("FAIL stall_release got %h", rsp_vec());
    end
    issue(1'b0, 2'd1, 4'b1111, 4'b0001, 32'h400);
    checks++;
    if (rsp_vec() !== {1'b1, 2'd1, 4'b0001, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1}) begin
      errors++; $display("FAIL ilv_split_w1 got %h", rsp_vec());
    end
    issue(1'b0, 2'd0, 4'b1001, 4'b0001, 32'h500);
    checks++;
    if (rsp_vec() !== {1'b1, 2'd0, 4'b0001, 32'h0, 1'b0, 1'b1, 1'b0, 2'd2}) begin
      errors++; $display("FAIL ilv_split_w0 got %h", rsp_vec());
    end
    issue(1'b1, 2'd1, 4'b0001, 4'b0000, 32'h0);
    checks++;
    if (rsp_vec() !== {1'b1, 2'd1, 4'b1110, 32'h400, 1'b1, 1'b0, 1'b0, 2'd1}) begin
      errors++; $display("FAIL ilv_join_w1 got %h", rsp_vec());
    end
    issue(1'b1, 2'd0, 4'b0001, 4'b0000, 32'h0);
    checks++;
    if (rsp_vec() !== {1'b1, 2'd0, 4'b1000, 32'h500, 1'b1, 1'b0, 1'b0, 2'd2}) begin
      errors++; $display("FAIL ilv_join_w0 got %h", rsp_vec());
    end
    checks++;
    if (warp_empty !== 4'b1100) begin errors++; $display("FAIL ilv_empty got %b exp 1100", warp_empty); end
  endtask

  task automatic test_mid_reset();
    rsp_ready = 1'b0;
    issue(1'b0, 2'd3, 4'b1111, 4'b0110, 32'h600);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; rsp_ready = 1'b1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", rsp_valid); end
    checks++;
    if (warp_empty !== 4'b1111) begin errors++; $display("FAIL midreset_empty got %b exp 1111", warp_empty); end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_split_join();
    test_overflow_lifo();
    test_underflow();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
